// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multicycle RISC-V control unit that issues ALU operations.
// Each instruction is stepped through fetch / decode / execute / writeback
// states. Outputs are decoded from the state register, and from funct3,
// funct7b5, zero and mem_ready where a state needs them, so the async reset
// drops every enable at once.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   i_opcode[6:0]      instr[6:0] from the instruction register
//   i_funct3[2:0]      instr[14:12]
//   i_funct7b5         instr[30]
//   i_zero             ALU zero flag for the current cycle
//   i_mem_ready        memory has completed the current access
//   o_alu_inst         ALU operation (ADD 0000, SUB 0001, AND 0010, OR 0011)
//   o_alu_src_a        00 PC, 01 oldPC, 10 rs1
//   o_alu_src_b        00 rs2, 01 imm, 10 const 4
//   o_result_src       00 ALUOut, 01 read data, 10 ALU result direct
//   o_imm_src          00 I, 01 S, 10 B, 11 J (from opcode in every state)
//   o_adr_src          0 PC, 1 result
//   o_pc_write, o_ir_write, o_reg_write, o_mem_write   write enables
//   o_instr_retire     one-cycle pulse on an instruction's final cycle
//   o_illegal          sticky trap indicator (held until reset)
module riscv_mc_ctrl #(
    parameter int INSTR_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [6:0]             i_opcode,
    input  logic [2:0]             i_funct3,
    input  logic                   i_funct7b5,
    input  logic                   i_zero,
    input  logic                   i_mem_ready,
    output logic [INSTR_WIDTH-1:0] o_alu_inst,
    output logic [1:0]             o_alu_src_a,
    output logic [1:0]             o_alu_src_b,
    output logic [1:0]             o_result_src,
    output logic [1:0]             o_imm_src,
    output logic                   o_adr_src,
    output logic                   o_pc_write,
    output logic                   o_ir_write,
    output logic                   o_reg_write,
    output logic                   o_mem_write,
    output logic                   o_instr_retire,
    output logic                   o_illegal
);

    localparam logic [3:0] S_RST      = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEMADR   = 4'd3;
    localparam logic [3:0] S_MEMREAD  = 4'd4;
    localparam logic [3:0] S_MEMWB    = 4'd5;
    localparam logic [3:0] S_MEMWRITE = 4'd6;
    localparam logic [3:0] S_EXECR    = 4'd7;
    localparam logic [3:0] S_EXECI    = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_ALUWB    = 4'd10;
    localparam logic [3:0] S_BEQ      = 4'd11;
    localparam logic [3:0] S_ILLEGAL  = 4'd12;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [INSTR_WIDTH-1:0] ALU_ADD = INSTR_WIDTH'(4'b0000);
    localparam logic [INSTR_WIDTH-1:0] ALU_SUB = INSTR_WIDTH'(4'b0001);
    localparam logic [INSTR_WIDTH-1:0] ALU_AND = INSTR_WIDTH'(4'b0010);
    localparam logic [INSTR_WIDTH-1:0] ALU_OR  = INSTR_WIDTH'(4'b0011);

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_f3_ok;

    // Only ADD/SUB (000), OR (110) and AND (111) are implemented for R/I.
    assign w_f3_ok = (i_funct3 == 3'b000) || (i_funct3 == 3'b110) ||
                     (i_funct3 == 3'b111);

    // State register; reset returns to RST immediately, mid-instruction too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; unused encodings fall into the absorbing trap.
    always_comb begin
        w_next = S_ILLEGAL;
        case (r_state)
            S_RST:      w_next = S_FETCH;
            S_FETCH:    w_next = i_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (i_opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = w_f3_ok ? S_EXECR : S_ILLEGAL;
                    OP_I:         w_next = w_f3_ok ? S_EXECI : S_ILLEGAL;
                    OP_BEQ:       w_next = (i_funct3 == 3'b000) ? S_BEQ : S_ILLEGAL;
                    OP_JAL:       w_next = S_JAL;
                    default:      w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                // Opcode is re-checked so a corrupted IR cannot slip through.
                if (i_opcode == OP_LW) begin
                    w_next = S_MEMREAD;
                end else if (i_opcode == OP_SW) begin
                    w_next = S_MEMWRITE;
                end else begin
                    w_next = S_ILLEGAL;
                end
            end
            S_MEMREAD:  w_next = i_mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = i_mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_JAL:      w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_ILLEGAL:  w_next = S_ILLEGAL;
            default:    w_next = S_ILLEGAL;
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        o_imm_src = 2'b00;
        case (i_opcode)
            OP_SW:   o_imm_src = 2'b01;
            OP_BEQ:  o_imm_src = 2'b10;
            OP_JAL:  o_imm_src = 2'b11;
            default: o_imm_src = 2'b00;
        endcase
    end

    // Per-state datapath controls; every field not set by a state stays 0.
    always_comb begin
        o_alu_inst     = ALU_ADD;
        o_alu_src_a    = 2'b00;
        o_alu_src_b    = 2'b00;
        o_result_src   = 2'b00;
        o_adr_src      = 1'b0;
        o_pc_write     = 1'b0;
        o_ir_write     = 1'b0;
        o_reg_write    = 1'b0;
        o_mem_write    = 1'b0;
        o_instr_retire = 1'b0;
        o_illegal      = 1'b0;
        case (r_state)
            S_FETCH: begin
                // PC+4 goes straight back to PC while the IR loads.
                o_alu_src_b  = 2'b10;
                o_result_src = 2'b10;
                o_ir_write   = i_mem_ready;
                o_pc_write   = i_mem_ready;
            end
            S_DECODE: begin
                // oldPC + imm: precomputed branch target lands in ALUOut.
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                o_alu_src_a = 2'b10;
                o_alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                o_adr_src = 1'b1;
            end
            S_MEMWB: begin
                o_result_src   = 2'b01;
                o_reg_write    = 1'b1;
                o_instr_retire = 1'b1;
            end
            S_MEMWRITE: begin
                o_adr_src      = 1'b1;
                o_mem_write    = 1'b1;
                o_instr_retire = i_mem_ready;
            end
            S_EXECR: begin
                o_alu_src_a = 2'b10;
                case (i_funct3)
                    3'b000:  o_alu_inst = i_funct7b5 ? ALU_SUB : ALU_ADD;
                    3'b111:  o_alu_inst = ALU_AND;
                    3'b110:  o_alu_inst = ALU_OR;
                    default: o_alu_inst = ALU_ADD;
                endcase
            end
            S_EXECI: begin
                // funct7b5 carries immediate bits here, so it never selects SUB.
                o_alu_src_a = 2'b10;
                o_alu_src_b = 2'b01;
                case (i_funct3)
                    3'b111:  o_alu_inst = ALU_AND;
                    3'b110:  o_alu_inst = ALU_OR;
                    default: o_alu_inst = ALU_ADD;
                endcase
            end
            S_JAL: begin
                // Return address oldPC+4 into ALUOut; jump target from ALUOut.
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b10;
                o_pc_write  = 1'b1;
            end
            S_ALUWB: begin
                o_reg_write    = 1'b1;
                o_instr_retire = 1'b1;
            end
            S_BEQ: begin
                o_alu_src_a    = 2'b10;
                o_alu_inst     = ALU_SUB;
                o_pc_write     = i_zero;
                o_instr_retire = 1'b1;
            end
            S_ILLEGAL: begin
                o_illegal = 1'b1;
            end
            default: begin
                o_illegal = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed bench for riscv_mc_ctrl: each step pushes the per-cycle expected
// control vector onto a scoreboard queue, then the queue is drained one clock
// at a time, driving mem_ready/zero and comparing on the falling edge.
module tb_riscv_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic [3:0] alu_inst;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
    logic       adr_src, pc_write, ir_write, reg_write, mem_write;
    logic       instr_retire, illegal;

    riscv_mc_ctrl #(.INSTR_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_opcode(opcode), .i_funct3(funct3), .i_funct7b5(funct7b5),
        .i_zero(zero), .i_mem_ready(mem_ready),
        .o_alu_inst(alu_inst), .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b),
        .o_result_src(result_src), .o_imm_src(imm_src), .o_adr_src(adr_src),
        .o_pc_write(pc_write), .o_ir_write(ir_write), .o_reg_write(reg_write),
        .o_mem_write(mem_write), .o_instr_retire(instr_retire), .o_illegal(illegal)
    );

    always #5 clk = ~clk;

    // {alu, src_a, src_b, result_src, imm_src, adr, pcw, irw, rw, mw, retire, illegal}
    logic [18:0] obs;
    assign obs = {alu_inst, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
                  pc_write, ir_write, reg_write, mem_write, instr_retire, illegal};

    logic [18:0] exp_q[$];
    logic        mr_q[$];
    logic        z_q[$];
    string       tag_q[$];

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [1:0]  cur_imm  = 2'b00;
    logic        cur_zero = 1'b0;

    function automatic logic [18:0] mk(input logic [3:0] alu, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] res,
                                       input logic adr, input logic pcw, input logic irw,
                                       input logic rw, input logic mw, input logic ret,
                                       input logic ill);
        return {alu, a, b, res, cur_imm, adr, pcw, irw, rw, mw, ret, ill};
    endfunction

    task automatic check(input string tag, input logic [18:0] e);
        n_chk++;
        assert (obs === e) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    endtask

    task automatic push(input string tag, input logic mr, input logic [18:0] e);
        tag_q.push_back(tag);
        mr_q.push_back(mr);
        z_q.push_back(cur_zero);
        exp_q.push_back(e);
    endtask

    task automatic p_rst();              push("RST",      1'b1, mk(4'h0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); endtask
    task automatic p_fetch(input logic mr); push("FETCH", mr,   mk(4'h0, 2'b00, 2'b10, 2'b10, 1'b0, mr,   mr,   1'b0, 1'b0, 1'b0, 1'b0)); endtask
    task automatic p_decode();           push("DECODE",   1'b1, mk(4'h0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); endtask
    task automatic p_memadr();           push("MEMADR",   1'b1, mk(4'h0, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); endtask
    task automatic p_memread(input logic mr); push("MEMREAD", mr, mk(4'h0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); endtask
    task automatic p_memwb();            push("MEMWB",    1'b1, mk(4'h0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0)); endtask
    task automatic p_memwrite(input logic mr); push("MEMWRITE", mr, mk(4'h0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mr, 1'b0)); endtask
    task automatic p_execr(input logic [3:0] alu); push("EXECR", 1'b1, mk(alu, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); endtask
    task automatic p_execi(input logic [3:0] alu); push("EXECI", 1'b1, mk(alu, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); endtask
    task automatic p_jal();              push("JAL",      1'b1, mk(4'h0, 2'b01, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); endtask
    task automatic p_aluwb();            push("ALUWB",    1'b1, mk(4'h0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0)); endtask
    task automatic p_beq();              push("BEQ",      1'b1, mk(4'h1, 2'b10, 2'b00, 2'b00, 1'b0, cur_zero, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)); endtask
    task automatic p_ill(input logic mr); push("ILLEGAL", mr,   mk(4'h0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)); endtask

    // Drive one queued cycle's inputs after the rising edge, compare on the falling edge.
    task automatic drain();
        while (exp_q.size() > 0) begin
            string       t;
            logic [18:0] e;
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            mem_ready = mr_q.pop_front();
            zero      = z_q.pop_front();
            @(negedge clk);
            check(t, e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic [1:0] imm);
        opcode   = op;
        funct3   = f3;
        funct7b5 = f7;
        cur_imm  = imm;
    endtask

    // One-cycle reset pulse starting just after a rising edge, then RST for one cycle.
    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        @(negedge clk);
        check(tag, mk(4'h0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        p_rst();
        drain();
    endtask

    task automatic run_r(input logic [2:0] f3, input logic f7, input logic [3:0] alu);
        set_instr(7'b0110011, f3, f7, 2'b00);
        p_fetch(1'b1); p_decode(); p_execr(alu); p_aluwb();
        drain();
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b1, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", mk(4'h0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        rst_n = 1'b1;
        p_rst();
        drain();

        // R-type: SUB, AND, OR, ADD
        run_r(3'b000, 1'b1, 4'b0001);
        run_r(3'b111, 1'b0, 4'b0010);
        run_r(3'b110, 1'b0, 4'b0011);
        run_r(3'b000, 1'b0, 4'b0000);

        // I-type ADD ignores funct7b5
        set_instr(7'b0010011, 3'b000, 1'b1, 2'b00);
        p_fetch(1'b1); p_decode(); p_execi(4'b0000); p_aluwb();
        drain();

        // I-type OR with two FETCH stall cycles
        set_instr(7'b0010011, 3'b110, 1'b0, 2'b00);
        p_fetch(1'b0); p_fetch(1'b0); p_fetch(1'b1); p_decode(); p_execi(4'b0011); p_aluwb();
        drain();

        // lw with three MEMREAD stall cycles: 8 cycles total
        set_instr(7'b0000011, 3'b010, 1'b0, 2'b00);
        p_fetch(1'b1); p_decode(); p_memadr();
        p_memread(1'b0); p_memread(1'b0); p_memread(1'b0); p_memread(1'b1);
        p_memwb();
        drain();

        // sw, no stall: 4 cycles, mem_write exactly one cycle
        set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);
        p_fetch(1'b1); p_decode(); p_memadr(); p_memwrite(1'b1);
        drain();

        // beq taken then not taken
        cur_zero = 1'b1;
        set_instr(7'b1100011, 3'b000, 1'b0, 2'b10);
        p_fetch(1'b1); p_decode(); p_beq();
        drain();
        cur_zero = 1'b0;
        p_fetch(1'b1); p_decode(); p_beq();
        drain();

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0, 2'b11);
        p_fetch(1'b1); p_decode(); p_jal(); p_aluwb();
        drain();

        // sw stalled in MEMWRITE, then async reset while mem_write is high
        set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);
        p_fetch(1'b1); p_decode(); p_memadr(); p_memwrite(1'b0);
        drain();
        mem_ready = 1'b0;
        @(negedge clk);
        check("sw_hold", mk(4'h0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", mk(4'h0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        p_rst();
        drain();

        // R-type funct3 010 traps; illegal sticks for 20 cycles with mem_ready toggling
        set_instr(7'b0110011, 3'b010, 1'b0, 2'b00);
        p_fetch(1'b1); p_decode();
        for (int i = 0; i < 20; i++) p_ill(i[0]);
        drain();
        reset_pulse("ill_rst_clear");

        // beq with funct3 001 traps
        set_instr(7'b1100011, 3'b001, 1'b0, 2'b10);
        p_fetch(1'b1); p_decode(); p_ill(1'b1); p_ill(1'b0);
        drain();
        reset_pulse("beq_rst_clear");

        // unknown opcode traps, then a normal instruction works after reset
        set_instr(7'b1111111, 3'b000, 1'b0, 2'b00);
        p_fetch(1'b1); p_decode(); p_ill(1'b1); p_ill(1'b1);
        drain();
        reset_pulse("op_rst_clear");
        run_r(3'b111, 1'b1, 4'b0010);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
